// File: rtl/m_shift_exec_pkg.sv
// Shift-op encodings, shift descriptor type and legality helper shared by the shift unit.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package m_shift_exec_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        SHIFT_SHL = 3'd0,
        SHIFT_SHR = 3'd1,
        SHIFT_ASR = 3'd2,
        SHIFT_ROL = 3'd3,
        SHIFT_ROR = 3'd4
    } e_shift_op;

    // op is kept as raw bits so reserved encodings 5..7 can be carried and flagged
    typedef struct packed {
        logic [2:0] op;
        logic [4:0] amount;
    } s_shift;

    function automatic logic f_shift_legal(input logic [2:0] op);
        return op <= 3'(SHIFT_ROR);
    endfunction

endpackage

// File: rtl/m_shift_stage.sv
// Combinational shifter/rotator: shifts din by amt*GRAN using op; reserved ops pass din through.
// Latency: 0 cycles (purely combinational).
// Backpressure: none, no state.
module m_shift_stage
    import m_shift_exec_pkg::*;
#(
    parameter int GRAN  = 4,
    parameter int AMT_W = 3
) (
    input  logic [2:0]        op,
    input  logic [AMT_W-1:0]  amt,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned SH_LSB = (GRAN == 4) ? 2 : 0;

    logic [4:0]          sh;
    logic [2*DATA_W-1:0] dbl;
    logic [2*DATA_W-1:0] rol_w;
    logic [2*DATA_W-1:0] ror_w;

    // Rotates use a doubled operand so the wrapped bits fall out of a plain shift
    always_comb begin
        sh    = 5'(amt) << SH_LSB;
        dbl   = {din, din};
        rol_w = dbl << sh;
        ror_w = dbl >> sh;
        case (op)
            3'(SHIFT_SHL): dout = din << sh;
            3'(SHIFT_SHR): dout = din >> sh;
            3'(SHIFT_ASR): dout = 32'($signed(din) >>> sh);
            3'(SHIFT_ROL): dout = rol_w[2*DATA_W-1:DATA_W];
            3'(SHIFT_ROR): dout = ror_w[DATA_W-1:0];
            default:       dout = din;
        endcase
    end

endmodule

// File: rtl/m_shift_exec.sv
// Execute-stage shift unit: coarse (x4) stage then fine (x1) stage, result + tag + illegal flag out.
// Latency: 2 cycles accept-to-out_valid, 1 op/cycle throughput.
// Backpressure: out_ready stalls s2 then s1; in_ready = !s1_valid || s2 advancing, forced 0 on flush/reset.
module m_shift_exec
    import m_shift_exec_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_shift,
    input  logic [DATA_W-1:0] in_operand,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal
);

    s_shift              in_desc;
    logic [DATA_W-1:0]   coarse_val;
    logic [DATA_W-1:0]   fine_val;
    logic                s2_adv;
    logic                s1_to_s2;
    logic                accept;

    logic                s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0]   s1_val_q, s1_val_d;
    logic [2:0]          s1_op_q, s1_op_d;
    logic [1:0]          s1_fine_q, s1_fine_d;
    logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;
    logic                s1_ill_q, s1_ill_d;

    logic                s2_vld_q, s2_vld_d;
    logic [DATA_W-1:0]   s2_res_q, s2_res_d;
    logic [TAG_W-1:0]    s2_tag_q, s2_tag_d;
    logic                s2_ill_q, s2_ill_d;

    assign in_desc = s_shift'(in_shift);

    m_shift_stage #(.GRAN(4), .AMT_W(3)) u_coarse (
        .op   (in_desc.op),
        .amt  (in_desc.amount[4:2]),
        .din  (in_operand),
        .dout (coarse_val)
    );

    m_shift_stage #(.GRAN(1), .AMT_W(2)) u_fine (
        .op   (s1_op_q),
        .amt  (s1_fine_q),
        .din  (s1_val_q),
        .dout (fine_val)
    );

    // Handshake: s2 drains on out_ready, s1 follows, input accepted when s1 frees up
    always_comb begin
        s2_adv   = !s2_vld_q || out_ready;
        s1_to_s2 = s1_vld_q && s2_adv;
        in_ready = rst_n && !flush && (!s1_vld_q || s2_adv);
        accept   = in_valid && in_ready;
    end

    // Next-state for both pipeline stages; flush only kills valids, data is don't-care
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_val_d  = s1_val_q;
        s1_op_d   = s1_op_q;
        s1_fine_d = s1_fine_q;
        s1_tag_d  = s1_tag_q;
        s1_ill_d  = s1_ill_q;
        s2_vld_d  = s2_vld_q;
        s2_res_d  = s2_res_q;
        s2_tag_d  = s2_tag_q;
        s2_ill_d  = s2_ill_q;

        if (accept) begin
            s1_vld_d  = 1'b1;
            s1_val_d  = coarse_val;
            s1_op_d   = in_desc.op;
            s1_fine_d = in_desc.amount[1:0];
            s1_tag_d  = in_tag;
            s1_ill_d  = !f_shift_legal(in_desc.op);
        end else if (s1_to_s2) begin
            s1_vld_d  = 1'b0;
        end

        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
        end
        if (s1_to_s2) begin
            s2_res_d = fine_val;
            s2_tag_d = s1_tag_q;
            s2_ill_d = s1_ill_q;
        end

        if (flush) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end
    end

    // Pipeline registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_val_q  <= '0;
            s1_op_q   <= '0;
            s1_fine_q <= '0;
            s1_tag_q  <= '0;
            s1_ill_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_res_q  <= '0;
            s2_tag_q  <= '0;
            s2_ill_q  <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_val_q  <= s1_val_d;
            s1_op_q   <= s1_op_d;
            s1_fine_q <= s1_fine_d;
            s1_tag_q  <= s1_tag_d;
            s1_ill_q  <= s1_ill_d;
            s2_vld_q  <= s2_vld_d;
            s2_res_q  <= s2_res_d;
            s2_tag_q  <= s2_tag_d;
            s2_ill_q  <= s2_ill_d;
        end
    end

    assign out_valid   = s2_vld_q;
    assign out_result  = s2_res_q;
    assign out_tag     = s2_tag_q;
    assign out_illegal = s2_ill_q;

endmodule

// File: tb/tb_m_shift_exec.sv
// Scoreboard bench for the two-stage shift unit: directed values, back-to-back, stall, flush, reset, random.
// Latency: checks 2-cycle accept-to-output where no backpressure is applied.
// Backpressure: drives out_ready low/random to exercise stall and ordering.
module tb_m_shift_exec;

    localparam int TAG_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_shift;
    logic [31:0]       in_operand;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              out_illegal;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic             ill;
        int               acc;
        bit               lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;
    int   cyc;
    bit   rnd_done;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    m_shift_exec #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_shift    (in_shift),
        .in_operand  (in_operand),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    task automatic chk_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference shift by the full amount in one step
    function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [4:0] amt,
                                              input logic [31:0] x);
        case (op)
            3'd0:    return x << amt;
            3'd1:    return x >> amt;
            3'd2:    return 32'($signed(x) >>> amt);
            3'd3:    return (amt == 0) ? x : ((x << amt) | (x >> (6'd32 - 6'(amt))));
            3'd4:    return (amt == 0) ? x : ((x >> amt) | (x << (6'd32 - 6'(amt))));
            default: return x;
        endcase
    endfunction

    // Output monitor: every transfer must match the oldest outstanding expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk_eq("spurious_out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk_eq("result", out_result, e.res);
                chk_eq("tag", 32'(out_tag), 32'(e.tag));
                chk_eq("illegal", {31'b0, out_illegal}, {31'b0, e.ill});
                if (e.lat) chk_eq("latency", 32'(cyc - e.acc), 32'd2);
            end
        end
    end

    // Offer one op starting at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [2:0] op, input logic [4:0] amt, input logic [31:0] x,
                        input logic [TAG_W-1:0] tag, input logic [31:0] exp_res,
                        input logic exp_ill, input bit lat, output int waited);
        waited     = 0;
        in_valid   = 1'b1;
        in_shift   = {op, amt};
        in_operand = x;
        in_tag     = tag;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 60) begin
                chk_eq("accept_timeout", {31'b0, in_ready}, 32'd1);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        sb.push_back('{exp_res, tag, exp_ill, cyc, lat});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk_eq("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin : main
        int          w;
        logic [31:0] held;
        logic [2:0]  rop;
        logic [4:0]  ramt;
        logic [31:0] rx;

        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_shift   = '0;
        in_operand = '0;
        in_tag     = '0;
        out_ready  = 1'b1;
        rnd_done   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk_eq("rst_out_result", out_result, 32'd0);
        chk_eq("rst_out_tag", 32'(out_tag), 32'd0);
        chk_eq("rst_out_illegal", {31'b0, out_illegal}, 32'd0);
        chk_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed values, full-rate output
        send(3'd0, 5'd4,  32'h0000_00FF, 5'd3,  32'h0000_0FF0, 1'b0, 1'b1, w);
        send(3'd2, 5'd31, 32'h8000_0000, 5'd4,  32'hFFFF_FFFF, 1'b0, 1'b1, w);
        send(3'd1, 5'd31, 32'h8000_0000, 5'd5,  32'h0000_0001, 1'b0, 1'b1, w);
        send(3'd4, 5'd1,  32'h0000_0001, 5'd6,  32'h8000_0000, 1'b0, 1'b1, w);
        send(3'd3, 5'd7,  32'h1234_5678, 5'd7,  32'h1A2B_3C09, 1'b0, 1'b1, w);
        send(3'd6, 5'd5,  32'hDEAD_BEEF, 5'd9,  32'hDEAD_BEEF, 1'b1, 1'b1, w);
        send(3'd3, 5'd0,  32'hCAFE_F00D, 5'd8,  32'hCAFE_F00D, 1'b0, 1'b1, w);
        drain();

        // Back-to-back accepts with no bubbles
        for (int i = 1; i <= 4; i++) begin
            send(3'd0, 5'(i), 32'h1, 5'(i), 32'h1 << i, 1'b0, 1'b1, w);
            chk_eq("b2b_no_stall", 32'(w), 32'd0);
        end
        drain();

        // Backpressure: two accepts fill the pipe, third offer stalls, output held
        out_ready = 1'b0;
        send(3'd1, 5'd8, 32'hAABB_CCDD, 5'd10, 32'h00AA_BBCC, 1'b0, 1'b0, w);
        send(3'd0, 5'd8, 32'hAABB_CCDD, 5'd11, 32'hBBCC_DD00, 1'b0, 1'b0, w);
        in_valid   = 1'b1;
        in_shift   = {3'd4, 5'd16};
        in_operand = 32'h1111_2222;
        in_tag     = 5'd12;
        @(negedge clk);
        chk_eq("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk_eq("bp_out_valid", {31'b0, out_valid}, 32'd1);
        held = out_result;
        repeat (3) begin
            @(negedge clk);
            chk_eq("bp_result_stable", out_result, held);
            chk_eq("bp_valid_stable", {31'b0, out_valid}, 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'd4, 5'd16, 32'h1111_2222, 5'd12, 32'h2222_1111, 1'b0, 1'b0, w);
        drain();

        // Flush with both stages full and output stalled
        out_ready = 1'b0;
        send(3'd0, 5'd1, 32'h0000_0003, 5'd13, 32'h0000_0006, 1'b0, 1'b0, w);
        send(3'd0, 5'd2, 32'h0000_0003, 5'd14, 32'h0000_000C, 1'b0, 1'b0, w);
        flush      = 1'b1;
        in_valid   = 1'b1;
        in_shift   = {3'd0, 5'd3};
        in_operand = 32'h0000_0003;
        in_tag     = 5'd15;
        @(negedge clk);
        chk_eq("flush_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk_eq("flush_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(3'd2, 5'd4, 32'hF000_0000, 5'd16, 32'hFF00_0000, 1'b0, 1'b1, w);
        drain();

        // Reset mid-operation with both stages valid
        out_ready = 1'b0;
        send(3'd1, 5'd1, 32'h0000_0010, 5'd17, 32'h0000_0008, 1'b0, 1'b0, w);
        send(3'd1, 5'd2, 32'h0000_0010, 5'd18, 32'h0000_0004, 1'b0, 1'b0, w);
        rst_n = 1'b0;
        @(negedge clk);
        chk_eq("mid_rst_in_ready_pre", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        sb.delete();
        @(negedge clk);
        chk_eq("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk_eq("mid_rst_out_result", out_result, 32'd0);
        chk_eq("mid_rst_out_tag", 32'(out_tag), 32'd0);
        chk_eq("mid_rst_out_illegal", {31'b0, out_illegal}, 32'd0);
        chk_eq("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(3'd3, 5'd4, 32'h8765_4321, 5'd19, 32'h7654_3218, 1'b0, 1'b1, w);
        drain();

        // Random ops with random downstream backpressure
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    rop  = 3'($urandom_range(0, 7));
                    ramt = 5'($urandom_range(0, 31));
                    rx   = $urandom;
                    send(rop, ramt, rx, 5'(i), ref_shift(rop, ramt, rx), (rop > 3'd4), 1'b0, w);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/m_shift_exec.md
Name: m_shift_exec

Overview:
- Execute-stage shift unit that consumes the decoded shift descriptor (s_shift: 3-bit shift op, 5-bit amount) produced by the decoder.
- Applies the shift to a 32-bit operand and returns the result with its destination tag.
- Two-stage pipeline: a coarse stage (shift by a multiple of 4) followed by a fine stage (shift by 0..3).
- Valid/ready handshakes on both sides; flush kills all in-flight operations.

Parameters:
TAG_W, 5, width of the opaque destination tag carried alongside each operation.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous kill of all in-flight operations
in_valid  in  1  upstream offers an operation
in_ready  out  1  unit accepts the operation this cycle
in_shift  in  8  s_shift descriptor: [7:5] op, [4:0] amount
in_operand  in  32  value to be shifted
in_tag  in  TAG_W  destination tag, passed through unchanged
out_valid  out  1  result available
out_ready  in  1  downstream accepts the result this cycle
out_result  out  32  shifted value
out_tag  out  TAG_W  tag of the result
out_illegal  out  1  op field was a reserved encoding

Behaviour:
- Op encodings:
  - SHL=0: logical left.
  - SHR=1: logical right.
  - ASR=2: arithmetic right.
  - ROL=3: rotate left.
  - ROR=4: rotate right.
  - 5..7 reserved.
- Accept: a transfer occurs when in_valid && in_ready. The operation is captured into stage 1 (s1).
- Stage 1 (coarse):
  - Shifts or rotates the operand by 4*amount[4:2], i.e. 0..28.
  - Registers the partial value, op, amount[1:0], tag and illegal flag.
- Stage 2 (fine):
  - Shifts or rotates the s1 value by amount[1:0] using the same op.
  - Registers the result into s2, which drives all out_* ports.
- Fill rules:
  - SHL/SHR fill with 0.
  - ASR fills with bit 31 of the stage input. Bit 31 remains the original sign after the coarse stage, so the composition is exact.
  - ROL/ROR wrap bits around; composing two rotates equals a rotate by the full amount.
- Amount 0 gives result = operand for every legal op. Amount 31 is the maximum; there is no amount ≥ 32.
- Reserved op:
  - out_result = operand unchanged.
  - out_illegal = 1.
  - Handshake behaviour is identical to a legal op.
- Latency and throughput:
  - Latency is 2 cycles from accept to out_valid when there is no backpressure.
  - Throughput is 1 operation per cycle.
- Flow control:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances into s2 when s1_valid and s2 advances.
  - in_ready = !s1_valid || (s2 advances).
  - in_ready is combinational from out_ready. There is no other combinational in-to-out path.
- Stall: under backpressure, s2 contents and out_* stay stable while out_valid=1 && !out_ready. Once asserted, out_valid does not deassert without a transfer, except on flush or reset.
- Flush:
  - Next cycle, s1_valid = s2_valid = 0.
  - in_ready is forced 0 during the flush cycle; any concurrent in_valid is dropped.
  - A result transferring in the flush cycle (out_valid && out_ready) is still considered delivered.
- Reset (rst_n=0 at an edge):
  - s1_valid = s2_valid = 0.
  - out_valid=0, out_result=0, out_tag=0, out_illegal=0.
  - in_ready=0 while rst_n=0.
  - Reset mid-operation discards all in-flight operations; there is no partial output.
- Simultaneous events: when s2 transfers out, s1 moves into s2 and a new input enters s1, all in the same cycle, with no bubble.

Decomposition:
- p_instruction additions:
  - e_shift_op enum (SHIFT_SHL, SHIFT_SHR, SHIFT_ASR, SHIFT_ROL, SHIFT_ROR).
  - s_shift typedef (op + 5-bit amount).
  - Helper function f_shift_legal.
- One natural sub-module: m_shift_stage, a combinational shifter parameterised by granularity (4 or 1). It is instantiated twice: coarse with amount[4:2], fine with amount[1:0].
- Pipeline registers and handshake logic stay in m_shift_exec.

Test Plan:
- Directed value checks, always with out_ready=1:
  - SHL 4 on 0x0000_00FF, tag 3 -> out_valid on cycle 2 after accept; result 0x0000_0FF0, tag 3, out_illegal=0.
  - ASR 31 on 0x8000_0000 -> 0xFFFF_FFFF.
  - SHR 31 on 0x8000_0000 -> 0x0000_0001.
  - ROR 1 on 0x0000_0001 -> 0x8000_0000.
  - ROL 7 on 0x1234_5678 -> 0x1A2B_3C09.
- Back-to-back: 4 consecutive accepts (SHL 1..4 on 0x1) with out_ready=1 -> results 0x2, 0x4, 0x8, 0x10 on consecutive cycles with no bubbles. in_ready stays 1 throughout.
- Backpressure: hold out_ready=0 after 2 accepts -> in_ready drops to 0 on the third offer. out_result is held stable. Raising out_ready then drains the results in order with correct tags.
- Reserved op 6 with amount 5 on 0xDEAD_BEEF -> result 0xDEAD_BEEF, out_illegal=1.
- Flush with both stages full and out_ready=0 -> out_valid=0 next cycle and no stale result is ever emitted. A new op accepted afterwards returns its correct result in 2 cycles.
- Reset mid-operation: rst_n=0 for 1 cycle with both stages valid -> all outputs are 0, in_ready=0 during reset. After release, normal 2-cycle latency resumes.
